// File: rtl/rmem_arb_pkg.sv
// rmem_arb_pkg: shared types and constants for the read-memory arbiter
package rmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEAD_BEEF;
  function automatic int cnt_w(input int t);
    return (t < 2) ? 1 : $clog2(t + 1);
  endfunction
endpackage

// File: rtl/rmem_rr_select.sv
// rmem_rr_select: combinational round-robin picker
//   pending : request vector
//   ptr     : highest-priority index
//   idx     : first pending index at or after ptr, cyclically
//   valid   : any bit of pending set
module rmem_rr_select #(
  parameter int N = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  pending,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          valid
);
  logic [IW-1:0] j;
  always_comb begin
    idx = '0;
    j = '0;
    // walk offsets from farthest to nearest so the nearest pending index wins
    for (int i = N - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % N);
      if (pending[j]) idx = j;
    end
  end
  assign valid = |pending;
endmodule

// File: rtl/rmem_arbiter.sv
// rmem_arbiter: round-robin sharing of one start/done read-memory port among N_REQ requesters
//   clk_i, rst_ni             : clock, async active-low reset
//   req_start_i, req_addr_i   : per-requester start pulse and address
//   req_done_o, req_rdata_o   : one-hot completion pulse and read data
//   req_timeout_o, req_drop_o : timeout flag with done, ignored-start pulse
//   mem_start_o, mem_addr_o   : downstream start pulse and address
//   mem_done_i, mem_rdata_i   : downstream done pulse and data
module rmem_arbiter
  import rmem_arb_pkg::*;
#(
  parameter int          N_REQ        = 2,
  parameter int          TIMEOUT      = 1024,
  parameter logic [31:0] TIMEOUT_DATA = TIMEOUT_DATA_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N_REQ-1:0]       req_start_i,
  input  logic [N_REQ-1:0][31:0] req_addr_i,
  output logic [N_REQ-1:0]       req_done_o,
  output logic [31:0]            req_rdata_o,
  output logic                   req_timeout_o,
  output logic [N_REQ-1:0]       req_drop_o,
  output logic                   mem_start_o,
  output logic [31:0]            mem_addr_o,
  input  logic                   mem_done_i,
  input  logic [31:0]            mem_rdata_i
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = cnt_w(TIMEOUT);
  state_t                   state;
  logic [N_REQ-1:0]         pending;
  logic [N_REQ-1:0][31:0]   addr_q;
  logic [IW-1:0]            grant;
  logic [IW-1:0]            rr_ptr;
  logic [IW-1:0]            pick;
  logic                     any;
  logic [CW-1:0]            cnt;
  logic [31:0]              data;
  logic                     tmo;
  logic                     resp;
  logic [N_REQ-1:0]         accept;
  logic [N_REQ-1:0]         clr;
  rmem_rr_select #(.N(N_REQ), .IW(IW)) u_sel (
    .pending(pending),
    .ptr(rr_ptr),
    .idx(pick),
    .valid(any)
  );
  assign resp = state == RESP;
  assign clr = resp ? N_REQ'(1) << grant : '0;
  // a start from the granted requester in its RESP cycle is accepted since its bit clears now
  always_comb begin
    accept = '0;
    for (int k = 0; k < N_REQ; k++) accept[k] = req_start_i[k] && (!pending[k] || clr[k]);
  end
  assign req_rdata_o = resp ? data : '0;
  assign req_timeout_o = resp & tmo;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      pending <= '0;
      addr_q <= '0;
      grant <= '0;
      rr_ptr <= '0;
      cnt <= '0;
      data <= '0;
      tmo <= 1'b0;
      req_done_o <= '0;
      req_drop_o <= '0;
      mem_start_o <= 1'b0;
      mem_addr_o <= '0;
    end else begin
      mem_start_o <= 1'b0;
      req_done_o <= '0;
      req_drop_o <= req_start_i & ~accept;
      pending <= (pending & ~clr) | accept;
      for (int k = 0; k < N_REQ; k++) if (accept[k]) addr_q[k] <= req_addr_i[k];
      case (state)
        IDLE: if (any) begin
          grant <= pick;
          mem_addr_o <= addr_q[pick];
          mem_start_o <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          cnt <= '0;
          state <= WAIT;
        end
        WAIT: if (mem_done_i) begin
          data <= mem_rdata_i;
          tmo <= 1'b0;
          req_done_o <= N_REQ'(1) << grant;
          state <= RESP;
        end else if (TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1)) begin
          data <= TIMEOUT_DATA;
          tmo <= 1'b1;
          req_done_o <= N_REQ'(1) << grant;
          state <= RESP;
        end else cnt <= cnt + 1'b1;
        RESP: begin
          rr_ptr <= (grant == IW'(N_REQ - 1)) ? '0 : grant + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rmem_arbiter.sv
// tb_rmem_arbiter: directed stimulus with a cycle-level behavioural model and literal checks
module tb_rmem_arbiter;
  localparam int N = 2;
  localparam int TO = 8;
  localparam logic [31:0] TDATA = 32'hDEAD_BEEF;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_start = '0;
  logic [N-1:0][31:0] req_addr = '0;
  logic [N-1:0] req_done;
  logic [31:0] req_rdata;
  logic req_timeout;
  logic [N-1:0] req_drop;
  logic mem_start;
  logic [31:0] mem_addr;
  logic mem_done = 1'b0;
  logic [31:0] mem_rdata = '0;
  int vectors = 0;
  int miscompares = 0;
  int n_start = 0;
  int n_done = 0;
  rmem_arbiter #(.N_REQ(N), .TIMEOUT(TO), .TIMEOUT_DATA(TDATA)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .req_start_i(req_start),
    .req_addr_i(req_addr),
    .req_done_o(req_done),
    .req_rdata_o(req_rdata),
    .req_timeout_o(req_timeout),
    .req_drop_o(req_drop),
    .mem_start_o(mem_start),
    .mem_addr_o(mem_addr),
    .mem_done_i(mem_done),
    .mem_rdata_i(mem_rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  // model: per-requester pending/address, one transaction tracked by its issue and response cycles
  bit m_pend [N];
  logic [31:0] m_addr [N];
  bit m_drop [N];
  int rr, g, c, t_issue, resp_c, idx;
  bit busy, m_to, found, in_resp;
  logic [31:0] m_rd, cur_addr;
  logic [N-1:0] e_done, e_drop;
  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_pend[k] = 0;
      m_addr[k] = '0;
      m_drop[k] = 0;
    end
    rr = 0; g = 0; busy = 0; resp_c = -1; t_issue = -10; m_rd = '0; m_to = 0; cur_addr = '0;
  endtask
  initial model_reset();
  always @(negedge clk) begin
    c++;
    if (!rst_n) model_reset();
    e_done = (resp_c == c) ? N'(1) << g : '0;
    for (int k = 0; k < N; k++) e_drop[k] = m_drop[k];
    chk("mem_start", 32'(mem_start), 32'(busy && c == t_issue));
    chk("mem_addr", mem_addr, cur_addr);
    chk("req_done", 32'(req_done), 32'(e_done));
    chk("req_drop", 32'(req_drop), 32'(e_drop));
    if (e_done != '0 || !rst_n) begin
      chk("req_rdata", req_rdata, (e_done != '0) ? m_rd : 32'h0);
      chk("req_timeout", 32'(req_timeout), 32'(e_done != '0 && m_to));
    end
    if (mem_start) n_start++;
    if (req_done != '0) n_done++;
    if (rst_n) begin
      for (int k = 0; k < N; k++) m_drop[k] = 0;
      in_resp = resp_c == c;
      if (busy && !in_resp && resp_c < 0 && c > t_issue) begin
        if (mem_done) begin
          resp_c = c + 1; m_rd = mem_rdata; m_to = 0;
        end else if (TO != 0 && c == t_issue + TO) begin
          resp_c = c + 1; m_rd = TDATA; m_to = 1;
        end
      end
      if (in_resp) begin
        m_pend[g] = 0; rr = (g + 1) % N; busy = 0; resp_c = -1;
      end else if (!busy) begin
        found = 0;
        for (int i = 0; i < N; i++) begin
          idx = (rr + i) % N;
          if (!found && m_pend[idx]) begin
            found = 1; g = idx;
          end
        end
        if (found) begin
          busy = 1; t_issue = c + 1; cur_addr = m_addr[g];
        end
      end
      for (int k = 0; k < N; k++) if (req_start[k]) begin
        if (m_pend[k]) m_drop[k] = 1;
        else begin
          m_pend[k] = 1; m_addr[k] = req_addr[k];
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
    req_start = '0;
    mem_done = 1'b0;
  endtask
  task automatic start(input int k, input logic [31:0] a);
    req_start[k] = 1'b1;
    req_addr[k] = a;
  endtask
  task automatic wait_issue();
    for (int i = 0; i < 20 && mem_start !== 1'b1; i++) step();
    chk("issue_seen", 32'(mem_start), 32'd1);
  endtask
  // returns in the response cycle so callers can act in it
  task automatic serve(input int k, input logic [31:0] a, input int lat, input logic [31:0] d);
    wait_issue();
    chk("issue_addr", mem_addr, a);
    repeat (lat) step();
    mem_done = 1'b1;
    mem_rdata = d;
    step();
    chk("done_vec", 32'(req_done), 32'(1 << k));
    chk("done_rdata", req_rdata, d);
    chk("done_tmo", 32'(req_timeout), 32'd0);
  endtask
  int s0;
  initial begin
    step();
    chk("rst_done", 32'(req_done), 32'd0);
    chk("rst_start", 32'(mem_start), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    rst_n = 1'b1;
    step();
    // single request: start at T, issue at T+2, done one cycle after mem_done
    start(0, 32'h40);
    step();
    chk("t1_no_issue", 32'(mem_start), 32'd0);
    step();
    chk("t1_issue_t2", 32'(mem_start), 32'd1);
    serve(0, 32'h40, 3, 32'h1234_5678);
    step();
    step();
    // fairness: restart from reset so the pointer begins at 0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int r = 0; r < 4; r++) begin
      start(0, 32'h100 + r);
      start(1, 32'h200 + r);
      step();
      serve(0, 32'h100 + r, 2, 32'hA000 + r);
      serve(1, 32'h200 + r, 1, 32'hB000 + r);
      step();
    end
    chk("fair_starts", n_start, n_done);
    // timeout: no mem_done, response at S+9
    start(0, 32'h80);
    step();
    wait_issue();
    chk("to_addr", mem_addr, 32'h80);
    repeat (TO) step();
    chk("to_early", 32'(req_done), 32'd0);
    step();
    chk("to_done", 32'(req_done), 32'd1);
    chk("to_rdata", req_rdata, 32'hDEAD_BEEF);
    chk("to_flag", 32'(req_timeout), 32'd1);
    step();
    mem_done = 1'b1;
    mem_rdata = 32'h5555;
    step();
    chk("late_done", 32'(req_done), 32'd0);
    step();
    // drop: second start while pending
    s0 = n_start;
    start(1, 32'h300);
    step();
    start(1, 32'h304);
    step();
    chk("drop_vec", 32'(req_drop), 32'h2);
    serve(1, 32'h300, 2, 32'hC0DE);
    repeat (5) step();
    chk("drop_one_txn", n_start - s0, 32'd1);
    // restart in own RESP cycle is accepted with the new address
    start(0, 32'h500);
    step();
    serve(0, 32'h500, 2, 32'h0F0F);
    start(0, 32'h504);
    step();
    chk("resp_nodrop", 32'(req_drop), 32'd0);
    serve(0, 32'h504, 1, 32'hF0F0);
    step();
    // reset in WAIT, then a stray mem_done
    start(1, 32'h600);
    step();
    wait_issue();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_start", 32'(mem_start), 32'd0);
    chk("rst_mid_addr", mem_addr, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    mem_done = 1'b1;
    mem_rdata = 32'h7777;
    step();
    chk("rst_stray_done", 32'(req_done), 32'd0);
    chk("rst_no_issue", 32'(mem_start), 32'd0);
    start(0, 32'h700);
    step();
    serve(0, 32'h700, 2, 32'h9999);
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rmem_arbiter.md
# rmem_arbiter

Sequences and shares the single coprocessor read-memory port (start/done/rdata handshake) among `N_REQ` requesters. Each requester posts a one-cycle start pulse with an address. The arbiter queues it as pending, grants requesters round-robin, and issues exactly one downstream transaction at a time. It returns the read data with a one-cycle done pulse and converts a missing downstream done into a timeout response.

## Interface
- `N_REQ`, 2: number of requesters (2..8).
- `TIMEOUT`, 1024: cycles waited for `mem_done_i` after issue; 0 disables the timeout.
- `TIMEOUT_DATA`, 32'hDEAD_BEEF: read data returned on a timeout.
- `clk_i`  in  1: clock; all state updates on the rising edge.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `req_start_i`  in  N_REQ: per-requester one-cycle start pulse.
- `req_addr_i`  in  N_REQ×32: per-requester address, sampled in the start cycle.
- `req_done_o`  out  N_REQ: one-hot one-cycle completion pulse.
- `req_rdata_o`  out  32: read data; valid only while some `req_done_o` bit is 1.
- `req_timeout_o`  out  1: high together with `req_done_o` when the response is a timeout.
- `req_drop_o`  out  N_REQ: one-cycle pulse when a start is ignored.
- `mem_start_o`  out  1: one-cycle downstream start pulse.
- `mem_addr_o`  out  32: address of the granted request; held stable from ISSUE through WAIT.
- `mem_done_i`  in  1: downstream one-cycle done pulse.
- `mem_rdata_i`  in  32: downstream data; valid while `mem_done_i` is 1.

## Operation
- Per requester there is a `pending[k]` bit and an address register.
  - A start while not pending sets `pending[k]` and latches the address.
  - A start while already pending is ignored, and `req_drop_o[k]` pulses in the following cycle.
- FSM states:
  - IDLE: if any pending bit is set, select the first pending index at or after `rr_ptr`, cyclically. Latch it as `grant`, load `mem_addr_o`, go to ISSUE.
  - ISSUE: `mem_start_o`=1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
  - WAIT: on `mem_done_i`=1, capture `mem_rdata_i` and go to RESP. Otherwise increment the counter. When the counter reaches `TIMEOUT`−1 (and `TIMEOUT`≠0), load `TIMEOUT_DATA`, set the timeout flag, and go to RESP.
  - RESP: `req_done_o[grant]`=1, `req_rdata_o` is the captured data, `req_timeout_o` is the flag. Clear `pending[grant]`, set `rr_ptr` = (grant+1) mod `N_REQ`, go to IDLE.
- `mem_done_i` outside WAIT is ignored. This covers late completions after a timeout and completions after reset.
- Simultaneous events:
  - A start from `grant` in the RESP cycle is accepted: set wins over clear, and the new address is latched; no drop.
  - Starts from other requesters are accepted in any state.
- Reset (including mid-transaction):
  - FSM to IDLE; pending, `grant`, `rr_ptr`, counter and data all cleared.
  - All outputs 0, including `mem_addr_o` and `req_rdata_o`.
  - An in-flight downstream transaction is abandoned.

## Timing
- Start in cycle T → pending at T+1 (IDLE grant) → `mem_start_o` at T+2.
- `mem_done_i` at cycle D (D ≥ T+3) → `req_done_o`/`req_rdata_o` at D+1.
- The arbiter is back in IDLE at D+2, so the next `mem_start_o` is no earlier than D+3.
- Timeout: with `mem_start_o` at cycle S, the timeout response appears at S+`TIMEOUT`+1.
- All outputs are registered, except that `req_rdata_o` and `req_timeout_o` are decoded from registers in RESP.

## Structure
- Package `rmem_arb_pkg`: FSM state enum (IDLE, ISSUE, WAIT, RESP), default `TIMEOUT_DATA` constant, and a counter-width function clog2(`TIMEOUT`+1).
- Sub-module `rmem_rr_select`: combinational round-robin picker.
  - Inputs: pending vector, `rr_ptr`.
  - Outputs: grant index, any-valid.
  - Reusable by other shared coprocessor resources.

## Test plan
- Single request: requester 0 starts at T with addr 0x40; memory done at S+3 with 0x1234_5678 → `mem_addr_o`=0x40, `mem_start_o` at T+2, `req_done_o`=01 with rdata 0x1234_5678 one cycle after done.
- Fairness: both requesters start in the same cycle, four repeated rounds → grants alternate 0,1,0,1; exactly one `mem_start_o` per done.
- Timeout: `TIMEOUT`=8, memory never responds → done with rdata 0xDEAD_BEEF and `req_timeout_o`=1 at S+9; a later `mem_done_i` produces no output.
- Drop and simultaneous events: requester 1 starts again while pending → `req_drop_o`=10 next cycle and only one transaction occurs. Requester 0 restarts in its RESP cycle → a second transaction is issued with the new address.
- Reset: assert `rst_ni` low in WAIT, release, then pulse `mem_done_i` → all outputs 0 and no `req_done_o`; a new request completes normally.
